// File: rtl/cc_sar_search_if.sv
// ---------------------------------------------------------------------------
// cc_sar_search_if
//   Groups the successive-approximation search handshake and the external
//   comparator connections into one bundle.
//
//   Signals (W = NUMBER_DATAWIDTH):
//     CC_SAR_SEARCH_start_In      1  request a new search (used only when idle)
//     CC_SAR_SEARCH_lessthan_In   1  comparator result: unknown X < trial
//     CC_SAR_SEARCH_trial_OutBUS  W  trial value fed to comparator operand B
//     CC_SAR_SEARCH_result_OutBUS W  search result (equals X after completion)
//     CC_SAR_SEARCH_busy_Out      1  search in progress (TEST or DONE)
//     CC_SAR_SEARCH_done_Out      1  one-cycle pulse, result valid
//
//   Modports:
//     master - requester / comparator side (drives start and lessthan)
//     slave  - the search engine
// ---------------------------------------------------------------------------
interface cc_sar_search_if #(
  parameter int NUMBER_DATAWIDTH = 8
);
  logic                        CC_SAR_SEARCH_start_In;
  logic                        CC_SAR_SEARCH_lessthan_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_trial_OutBUS;
  logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_result_OutBUS;
  logic                        CC_SAR_SEARCH_busy_Out;
  logic                        CC_SAR_SEARCH_done_Out;

  modport master (
    output CC_SAR_SEARCH_start_In,
    output CC_SAR_SEARCH_lessthan_In,
    input  CC_SAR_SEARCH_trial_OutBUS,
    input  CC_SAR_SEARCH_result_OutBUS,
    input  CC_SAR_SEARCH_busy_Out,
    input  CC_SAR_SEARCH_done_Out
  );

  modport slave (
    input  CC_SAR_SEARCH_start_In,
    input  CC_SAR_SEARCH_lessthan_In,
    output CC_SAR_SEARCH_trial_OutBUS,
    output CC_SAR_SEARCH_result_OutBUS,
    output CC_SAR_SEARCH_busy_Out,
    output CC_SAR_SEARCH_done_Out
  );
endinterface

// File: rtl/cc_sar_search.sv
// ---------------------------------------------------------------------------
// cc_sar_search
//   Successive-approximation search for an unknown value X that lives behind
//   an external combinational comparator. One bit is decided per clock, MSB
//   first; a W-bit search takes W TEST cycles plus one DONE cycle.
//
//   Ports:
//     CC_SAR_SEARCH_CLOCK_50      in   clock, rising edge
//     CC_SAR_SEARCH_RESET_InHigh  in   synchronous active-high reset
//     bus                         slave modport of cc_sar_search_if
//                                 (start/lessthan in, trial/result/busy/done out)
// ---------------------------------------------------------------------------
module cc_sar_search #(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input  logic              CC_SAR_SEARCH_CLOCK_50,
  input  logic              CC_SAR_SEARCH_RESET_InHigh,
  cc_sar_search_if.slave    bus
);
  localparam int W  = NUMBER_DATAWIDTH;
  localparam int IW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    trial_reg, trial_next;
  logic [W-1:0]    result_reg, result_next;
  logic [IW-1:0]   index_reg, index_next;
  logic [W-1:0]    acc;
  logic            busy, done;

  // State and datapath registers
  always_ff @(posedge CC_SAR_SEARCH_CLOCK_50) begin
    if (CC_SAR_SEARCH_RESET_InHigh) begin
      state_reg  <= IDLE;
      trial_reg  <= '0;
      result_reg <= '0;
      index_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      trial_reg  <= trial_next;
      result_reg <= result_next;
      index_reg  <= index_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next  = state_reg;
    trial_next  = trial_reg;
    result_next = result_reg;
    index_next  = index_reg;

    // The trial currently presented already carries the bit under test set;
    // the comparator decides whether that bit survives.
    acc = trial_reg;
    if (bus.CC_SAR_SEARCH_lessthan_In) begin
      acc[index_reg] = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        trial_next = '0;
        if (bus.CC_SAR_SEARCH_start_In) begin
          state_next  = TEST;
          trial_next  = {1'b1, {(W-1){1'b0}}};
          result_next = '0;
          index_next  = IW'(W-1);
        end
      end
      TEST: begin
        if (index_reg == '0) begin
          // Last bit decided: publish the result, trial keeps its last value
          result_next = acc;
          state_next  = DONE;
        end else begin
          trial_next = acc | (W'(1) << (index_reg - 1'b1));
          index_next = index_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        trial_next = '0;
      end
      default: begin
        state_next = IDLE;
        trial_next = '0;
      end
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      TEST:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.CC_SAR_SEARCH_trial_OutBUS  = trial_reg;
  assign bus.CC_SAR_SEARCH_result_OutBUS = result_reg;
  assign bus.CC_SAR_SEARCH_busy_Out      = busy;
  assign bus.CC_SAR_SEARCH_done_Out      = done;

endmodule

// File: tb/tb_cc_sar_search.sv
// ---------------------------------------------------------------------------
// tb_cc_sar_search
//   Self-checking bench for cc_sar_search (W = 8). A behavioural comparator
//   sits on the interface; expected results are queued when a search is
//   started and popped by a monitor whenever done is seen.
// ---------------------------------------------------------------------------
module tb_cc_sar_search;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         srst;
  logic         start;
  logic [W-1:0] x_val;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_tr [8];
  logic [W-1:0] a5_tr  [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  cc_sar_search_if #(.NUMBER_DATAWIDTH(W)) bus ();

  assign bus.CC_SAR_SEARCH_start_In    = start;
  assign bus.CC_SAR_SEARCH_lessthan_In = (x_val < bus.CC_SAR_SEARCH_trial_OutBUS);

  cc_sar_search #(.NUMBER_DATAWIDTH(W)) dut (
    .CC_SAR_SEARCH_CLOCK_50     (clk),
    .CC_SAR_SEARCH_RESET_InHigh (srst),
    .bus                        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest queued expectation
  always @(negedge clk) begin
    if (!srst) begin
      if (bus.CC_SAR_SEARCH_busy_Out) busy_cnt++;
      else                            busy_cnt = 0;
      if (bus.CC_SAR_SEARCH_done_Out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("result", 32'(bus.CC_SAR_SEARCH_result_OutBUS), 32'(e));
          check("busy_len", 32'(busy_cnt), 32'd9);
          $display("search X=%02h result=%02h", e, bus.CC_SAR_SEARCH_result_OutBUS);
        end
      end
    end
  end

  // Independent trial model: greedy MSB-first build of the largest value <= X
  task automatic build_trials(input logic [W-1:0] x);
    logic [W-1:0] a, t;
    a = '0;
    for (int b = W-1; b >= 0; b--) begin
      t = a | (W'(1) << b);
      exp_tr[W-1-b] = t;
      if (!(x < t)) a = t;
    end
  endtask

  // Cycle-accurate search with trial checks; optional start re-pulse or
  // reset injected during a given TEST cycle (1..8, 0 = none)
  task automatic directed_search(input logic [W-1:0] x, input int repulse_at, input int reset_at);
    build_trials(x);
    @(negedge clk);
    x_val = x;
    start = 1'b1;
    exp_q.push_back(x);
    for (int cyc = 1; cyc <= W; cyc++) begin
      @(negedge clk);
      start = (cyc == repulse_at);
      check($sformatf("trial_c%0d", cyc), 32'(bus.CC_SAR_SEARCH_trial_OutBUS),
            32'((x == 8'hA5) ? a5_tr[cyc-1] : exp_tr[cyc-1]));
      check("busy_test", 32'(bus.CC_SAR_SEARCH_busy_Out), 32'd1);
      if (cyc == reset_at) begin
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        exp_q.delete();
        check("rst_trial", 32'(bus.CC_SAR_SEARCH_trial_OutBUS), 32'd0);
        check("rst_result", 32'(bus.CC_SAR_SEARCH_result_OutBUS), 32'd0);
        check("rst_busy", 32'(bus.CC_SAR_SEARCH_busy_Out), 32'd0);
        check("rst_done", 32'(bus.CC_SAR_SEARCH_done_Out), 32'd0);
        $display("reset injected in TEST cycle %0d", cyc);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_latency", 32'(bus.CC_SAR_SEARCH_done_Out), 32'd1);
    check("trial_hold", 32'(bus.CC_SAR_SEARCH_trial_OutBUS), 32'(exp_tr[W-1]));
    @(negedge clk);
    check("idle_done", 32'(bus.CC_SAR_SEARCH_done_Out), 32'd0);
    check("idle_busy", 32'(bus.CC_SAR_SEARCH_busy_Out), 32'd0);
    check("idle_trial", 32'(bus.CC_SAR_SEARCH_trial_OutBUS), 32'd0);
    check("idle_result", 32'(bus.CC_SAR_SEARCH_result_OutBUS), 32'(x));
  endtask

  // Plain search, bounded wait for done; the monitor checks the result
  task automatic run_search(input logic [W-1:0] x);
    int c;
    @(negedge clk);
    x_val = x;
    start = 1'b1;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!bus.CC_SAR_SEARCH_done_Out && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!bus.CC_SAR_SEARCH_done_Out) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_done, n_done;
    srst  = 1'b1;
    start = 1'b1;   // reset must win over start
    x_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_trial", 32'(bus.CC_SAR_SEARCH_trial_OutBUS), 32'd0);
    check("reset_result", 32'(bus.CC_SAR_SEARCH_result_OutBUS), 32'd0);
    check("reset_busy", 32'(bus.CC_SAR_SEARCH_busy_Out), 32'd0);
    check("reset_done", 32'(bus.CC_SAR_SEARCH_done_Out), 32'd0);
    start = 1'b0;
    srst  = 1'b0;
    repeat (3) @(negedge clk);
    check("no_auto_start", 32'(bus.CC_SAR_SEARCH_busy_Out), 32'd0);

    directed_search(8'hA5, 0, 0);
    directed_search(8'h00, 0, 0);
    directed_search(8'hFF, 0, 0);
    directed_search(8'hA5, 3, 0);
    repeat (12) @(negedge clk);   // a restarted search would raise an extra done
    directed_search(8'h5A, 0, 4);
    repeat (12) @(negedge clk);   // aborted search must never signal done
    directed_search(8'h37, 0, 0);

    for (int x = 0; x < (1 << W); x++) run_search(W'(x));

    // Start held high for 30 cycles: searches back to back every W+2 cycles
    @(negedge clk);
    x_val = 8'h3C;
    start = 1'b1;
    repeat (3) exp_q.push_back(8'h3C);
    last_done = 0;
    n_done    = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 30) start = 1'b0;
      if (bus.CC_SAR_SEARCH_done_Out) begin
        check("held_period", 32'(c - last_done), (n_done == 0) ? 32'd9 : 32'd10);
        last_done = c;
        n_done++;
      end
    end
    repeat (12) @(negedge clk);
    check("held_count", 32'(n_done), 32'd3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
